// File: rtl/win_pkg.sv
`default_nettype none
// ============================================================================
// Module   : win_pkg
// Purpose  : Shared window state encoding and width-derivation helper.
// Revision : 1.0 - initial release
// ============================================================================
package win_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } win_state_e;

    // Ceiling log2; exact for the power-of-two depths this block accepts.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_shift_reg_if.sv
`default_nettype none
// ============================================================================
// Module   : window_shift_reg_if
// Purpose  : Sample input and window output bundle for window_shift_reg.
// Revision : 1.0 - initial release
// ============================================================================
interface window_shift_reg_if
    import win_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8
) ();
    localparam int SUM_W = WIDTH + log2(DEPTH);
    localparam int CNT_W = log2(DEPTH) + 1;

    logic signed [WIDTH-1:0]       din;
    logic                          din_valid;
    logic                          hold;
    logic                          clear;
    logic        [WIDTH*DEPTH-1:0] taps;
    logic signed [SUM_W-1:0]       win_sum;
    logic        [CNT_W-1:0]       fill_cnt;
    logic                          win_full;
    logic                          out_strobe;

    modport master (
        output din, din_valid, hold, clear,
        input  taps, win_sum, fill_cnt, win_full, out_strobe
    );

    modport slave (
        input  din, din_valid, hold, clear,
        output taps, win_sum, fill_cnt, win_full, out_strobe
    );
endinterface
`default_nettype wire

// File: rtl/hop_counter.sv
`default_nettype none
// ============================================================================
// Module   : hop_counter
// Purpose  : Counts accepts while the window is full and pulses strobe on
//            window entry and on every HOP-th accept thereafter.
// Revision : 1.0 - initial release
// ============================================================================
module hop_counter #(
    parameter int HOP = 1
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear,
    input  wire logic step,
    input  wire logic restart,
    output logic      strobe
);
    localparam int HC_W = (HOP > 1) ? $clog2(HOP) : 1;

    logic [HC_W-1:0] cnt_q;
    logic            strobe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else if (clear) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
        end else if (restart) begin
            cnt_q    <= '0;
            strobe_q <= 1'b1;
        end else if (step) begin
            if (cnt_q == HC_W'(HOP - 1)) begin
                cnt_q    <= '0;
                strobe_q <= 1'b1;
            end else begin
                cnt_q    <= cnt_q + HC_W'(1);
                strobe_q <= 1'b0;
            end
        end else begin
            strobe_q <= 1'b0;
        end
    end

    assign strobe = strobe_q;

endmodule
`default_nettype wire

// File: rtl/window_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : window_shift_reg
// Purpose  : Sliding window of DEPTH signed samples with running sum, fill
//            tracking and hop-aligned output strobe.
// Revision : 1.0 - initial release
// ============================================================================
module window_shift_reg
    import win_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 8,
    parameter int HOP   = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    window_shift_reg_if.slave win
);
    localparam int SUM_W = WIDTH + log2(DEPTH);
    localparam int CNT_W = log2(DEPTH) + 1;

    win_state_e              state_q, state_d;
    logic [WIDTH-1:0]        taps_q [DEPTH];
    logic [WIDTH-1:0]        taps_d [DEPTH];
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [SUM_W-1:0] din_ext, old_ext;
    logic                    accept, enter_full, step_full;

    always_comb begin
        accept     = win.din_valid & ~win.hold & ~win.clear;
        enter_full = accept && (state_q != FULL) && (cnt_q == CNT_W'(DEPTH - 1));
        step_full  = accept && (state_q == FULL);
        din_ext    = {{(SUM_W-WIDTH){win.din[WIDTH-1]}}, win.din};
        old_ext    = {{(SUM_W-WIDTH){taps_q[DEPTH-1][WIDTH-1]}}, taps_q[DEPTH-1]};

        taps_d  = taps_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        state_d = state_q;

        if (win.clear) begin
            for (int k = 0; k < DEPTH; k++) taps_d[k] = '0;
            sum_d   = '0;
            cnt_d   = '0;
            state_d = EMPTY;
        end else if (accept) begin
            taps_d[0] = win.din;
            for (int k = 1; k < DEPTH; k++) taps_d[k] = taps_q[k-1];
            // Zero-filled taps make the incremental update exact during fill too.
            sum_d = sum_q + din_ext - old_ext;
            if (state_q != FULL) begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = enter_full ? FULL : FILLING;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) taps_q[k] <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            state_q <= EMPTY;
        end else begin
            taps_q  <= taps_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    hop_counter #(
        .HOP (HOP)
    ) u_hop (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (win.clear),
        .step    (step_full),
        .restart (enter_full),
        .strobe  (win.out_strobe)
    );

    for (genvar k = 0; k < DEPTH; k++) begin : g_taps
        assign win.taps[k*WIDTH +: WIDTH] = taps_q[k];
    end

    assign win.win_sum  = sum_q;
    assign win.fill_cnt = cnt_q;
    assign win.win_full = (state_q == FULL);

endmodule
`default_nettype wire

// File: tb/tb_window_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_window_shift_reg
// Purpose  : Directed self-checking bench for window_shift_reg (HOP=1 and 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_window_shift_reg;
    localparam int WIDTH = 37;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    window_shift_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if1 ();
    window_shift_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if4 ();

    window_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOP(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .win(if1.slave));
    window_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .HOP(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .win(if4.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: newest-first sample list, fill count, accepts since full.
    logic signed [WIDTH-1:0] m_taps [DEPTH] = '{default: '0};
    int     m_fill  = 0;
    longint m_nfull = -1;
    bit     m_str1  = 1'b0;
    bit     m_str4  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || if1.clear) begin
            for (int k = 0; k < DEPTH; k++) m_taps[k] <= '0;
            m_fill  <= 0;
            m_nfull <= -1;
            m_str1  <= 1'b0;
            m_str4  <= 1'b0;
        end else if (if1.hold || !if1.din_valid) begin
            m_str1 <= 1'b0;
            m_str4 <= 1'b0;
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) m_taps[k] <= m_taps[k-1];
            m_taps[0] <= if1.din;
            if (m_fill < DEPTH) m_fill <= m_fill + 1;
            if (m_fill >= DEPTH - 1) begin
                m_nfull <= m_nfull + 1;
                m_str1  <= ((m_nfull + 1) % 1) == 0;
                m_str4  <= ((m_nfull + 1) % 4) == 0;
            end else begin
                m_str1 <= 1'b0;
                m_str4 <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_taps(input string name, input logic [WIDTH*DEPTH-1:0] act,
                              input logic [WIDTH*DEPTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint tap(input logic [WIDTH*DEPTH-1:0] vec, input int k);
        logic signed [WIDTH-1:0] t;
        t = vec[k*WIDTH +: WIDTH];
        return longint'(t);
    endfunction

    logic [WIDTH*DEPTH-1:0] exp_taps;
    longint                 exp_sum;

    always @(negedge clk) begin
        exp_sum = 0;
        for (int k = 0; k < DEPTH; k++) begin
            exp_taps[k*WIDTH +: WIDTH] = m_taps[k];
            exp_sum += longint'(m_taps[k]);
        end
        check_taps("taps1", if1.taps, exp_taps);
        check_taps("taps4", if4.taps, exp_taps);
        check("sum1", longint'(if1.win_sum), exp_sum);
        check("sum4", longint'(if4.win_sum), exp_sum);
        check("fill1", longint'(if1.fill_cnt), longint'(m_fill));
        check("fill4", longint'(if4.fill_cnt), longint'(m_fill));
        check("full1", longint'(if1.win_full), longint'(m_fill == DEPTH));
        check("full4", longint'(if4.win_full), longint'(m_fill == DEPTH));
        check("strobe1", longint'(if1.out_strobe), longint'(m_str1));
        check("strobe4", longint'(if4.out_strobe), longint'(m_str4));
    end

    task automatic cyc(input bit v, input longint d, input bit h, input bit c);
        logic [63:0] dv;
        dv = d;
        if1.din = dv[WIDTH-1:0];  if4.din = dv[WIDTH-1:0];
        if1.din_valid = v;        if4.din_valid = v;
        if1.hold = h;             if4.hold = h;
        if1.clear = c;            if4.clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input longint d);
        cyc(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_fill"}, longint'(if1.fill_cnt), 0);
        check({tag, "_sum"}, longint'(if1.win_sum), 0);
        check({tag, "_full"}, longint'(if1.win_full), 0);
        check({tag, "_strobe"}, longint'(if1.out_strobe), 0);
        check_taps({tag, "_taps"}, if1.taps, '0);
        check({tag, "_fill4"}, longint'(if4.fill_cnt), 0);
        check({tag, "_sum4"}, longint'(if4.win_sum), 0);
    endtask

    initial begin
        rst_n = 1'b1;
        if1.din = '0; if1.din_valid = 1'b0; if1.hold = 1'b0; if1.clear = 1'b0;
        if4.din = '0; if4.din_valid = 1'b0; if4.hold = 1'b0; if4.clear = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;

        // Fill with 1..8, then one more sample.
        for (int i = 1; i <= 7; i++) acc(i);
        check("fill7_full", longint'(if1.win_full), 0);
        check("fill7_strobe", longint'(if1.out_strobe), 0);
        acc(8);
        check("full_flag", longint'(if1.win_full), 1);
        check("full_cnt", longint'(if1.fill_cnt), 8);
        check("full_sum", longint'(if1.win_sum), 36);
        check("full_tap0", tap(if1.taps, 0), 8);
        check("full_tap7", tap(if1.taps, 7), 1);
        check("full_strobe1", longint'(if1.out_strobe), 1);
        check("full_strobe4", longint'(if4.out_strobe), 1);
        cyc(1'b0, 0, 1'b0, 1'b0);
        check("idle_strobe", longint'(if1.out_strobe), 0);
        acc(9);
        check("acc9_sum", longint'(if1.win_sum), 44);
        check("acc9_tap7", tap(if1.taps, 7), 2);
        check("acc9_strobe1", longint'(if1.out_strobe), 1);
        check("acc9_strobe4", longint'(if4.out_strobe), 0);

        cyc(1'b1, 99, 1'b0, 1'b1);
        check_zero("clear_full");

        // Hop spacing: HOP=4 strobes after accepts 8, 12, 16 only.
        for (int i = 1; i <= 16; i++) begin
            acc(i * 3);
            check($sformatf("hop4_acc%0d", i), longint'(if4.out_strobe),
                  longint'(i == 8 || i == 12 || i == 16));
            check($sformatf("hop1_acc%0d", i), longint'(if1.out_strobe), longint'(i >= 8));
        end

        // Extreme values: exact sum with no overflow.
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) acc(-(64'sd1 <<< 36));
        check("min_sum", longint'(if1.win_sum), -(64'sd1 <<< 39));
        for (int i = 0; i < 8; i++) acc((64'sd1 <<< 36) - 1);
        check("max_sum", longint'(if1.win_sum), (64'sd1 <<< 39) - 8);

        // Hold, idle, and clear-beats-hold at fill_cnt = 5.
        cyc(1'b0, 0, 1'b0, 1'b1);
        for (int i = 10; i <= 14; i++) acc(i);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 77, 1'b1, 1'b0);
            check("hold_fill", longint'(if1.fill_cnt), 5);
            check("hold_sum", longint'(if1.win_sum), 60);
            check("hold_tap0", tap(if1.taps, 0), 14);
        end
        cyc(1'b0, 55, 1'b0, 1'b0);
        check("novalid_sum", longint'(if1.win_sum), 60);
        cyc(1'b1, 88, 1'b1, 1'b1);
        check_zero("clear_hold");

        // Asynchronous reset while full.
        for (int i = 1; i <= 8; i++) acc(i);
        check("pre_rst_full", longint'(if1.win_full), 1);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 7; i++) acc(i);
        check("refill7_full", longint'(if1.win_full), 0);
        check("refill7_cnt", longint'(if1.fill_cnt), 7);
        acc(8);
        check("refill8_full", longint'(if1.win_full), 1);
        check("refill8_strobe", longint'(if1.out_strobe), 1);
        cyc(1'b0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
